// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// Address/data widths, write request bundle and grant encoding.
package regfile_pkg;
  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int NREGS = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  typedef enum logic {GNT_A, GNT_B} grant_e;

  function automatic logic [NREGS-1:0] onehot(
    input logic [AW-1:0] a
  );
    logic [NREGS-1:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester and register-file side signals of the write arbiter.
// master drives requests; slave is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int DEPTH = 2
);
  import regfile_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             a_valid;
  logic             a_ready;
  logic [AW-1:0]    a_addr;
  logic [DW-1:0]    a_data;
  logic             b_valid;
  logic             b_ready;
  logic [AW-1:0]    b_addr;
  logic [DW-1:0]    b_data;
  logic             regWr;
  logic [AW-1:0]    rw;
  logic [DW-1:0]    busW;
  logic [NREGS-1:0] pending;
  logic [CW-1:0]    a_count;
  logic [CW-1:0]    b_count;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready,
    input  regWr, rw, busW, pending,
    input  a_count, b_count
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready,
    output regWr, rw, busW, pending,
    output a_count, b_count
  );
endinterface

// File: rtl/regfile_wr_arbiter_fifo.sv
// Per-requester write FIFO; exposes per-entry valid and address
// so the top level can build the pending-register mask.
module wr_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  wr_req_t                     din,
  output wr_req_t                     dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0]            vld,
  output logic [DEPTH-1:0][AW-1:0]    addr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t          r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [DEPTH-1:0] r_vld;
  logic [DEPTH-1:0] w_vld_nxt;

  always_comb begin
    w_vld_nxt = r_vld;
    if (pop)  w_vld_nxt[r_rp] = 1'b0;
    if (push) w_vld_nxt[r_wp] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      if (push) begin
        r_mem[r_wp] <= din;
        r_wp        <= r_wp + PW'(1);
      end
      if (pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
      r_vld <= w_vld_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) addr[i] = r_mem[i].addr;
  end

  assign dout  = r_mem[r_rp];
  assign full  = (r_cnt == CW'(DEPTH));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign vld   = r_vld;
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester round-robin arbiter for the single register-file
// write port, with per-requester FIFOs and a pending-write mask.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst,
  regfile_wr_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  wr_req_t                 w_a_din, w_b_din;
  wr_req_t                 w_a_dout, w_b_dout;
  logic                    w_a_full, w_b_full;
  logic                    w_a_empty, w_b_empty;
  logic [CW-1:0]           w_a_cnt, w_b_cnt;
  logic [DEPTH-1:0]        w_a_vld, w_b_vld;
  logic [DEPTH-1:0][AW-1:0] w_a_addr, w_b_addr;
  logic                    w_a_push, w_b_push;
  logic                    w_gnt_a, w_gnt_b;
  grant_e                  r_last, w_last_nxt;
  logic                    r_regWr;
  logic [AW-1:0]           r_rw;
  logic [DW-1:0]           r_busW;
  logic [NREGS-1:0]        w_pend;

  assign w_a_din  = '{addr: bus.a_addr, data: bus.a_data};
  assign w_b_din  = '{addr: bus.b_addr, data: bus.b_data};
  assign w_a_push = bus.a_valid && !w_a_full && !rst;
  assign w_b_push = bus.b_valid && !w_b_full && !rst;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst),
    .push(w_a_push), .pop(w_gnt_a),
    .din(w_a_din), .dout(w_a_dout),
    .full(w_a_full), .empty(w_a_empty),
    .count(w_a_cnt), .vld(w_a_vld), .addr(w_a_addr)
  );

  wr_fifo #(.DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst),
    .push(w_b_push), .pop(w_gnt_b),
    .din(w_b_din), .dout(w_b_dout),
    .full(w_b_full), .empty(w_b_empty),
    .count(w_b_cnt), .vld(w_b_vld), .addr(w_b_addr)
  );

  // On a tie the requester not served last wins.
  assign w_gnt_a = !w_a_empty && (w_b_empty || r_last == GNT_B);
  assign w_gnt_b = !w_b_empty && (w_a_empty || r_last == GNT_A);

  always_comb begin
    w_last_nxt = r_last;
    unique case (1'b1)
      w_gnt_a: w_last_nxt = GNT_A;
      w_gnt_b: w_last_nxt = GNT_B;
      default: w_last_nxt = r_last;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last  <= GNT_B;
      r_regWr <= 1'b0;
      r_rw    <= '0;
      r_busW  <= '0;
    end else begin
      r_last  <= w_last_nxt;
      r_regWr <= w_gnt_a || w_gnt_b;
      if (w_gnt_a) begin
        r_rw   <= w_a_dout.addr;
        r_busW <= w_a_dout.data;
      end else if (w_gnt_b) begin
        r_rw   <= w_b_dout.addr;
        r_busW <= w_b_dout.data;
      end
    end
  end

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_a_vld[i]) w_pend = w_pend | onehot(w_a_addr[i]);
      if (w_b_vld[i]) w_pend = w_pend | onehot(w_b_addr[i]);
    end
    if (r_regWr) w_pend = w_pend | onehot(r_rw);
  end

  assign bus.a_ready = !w_a_full;
  assign bus.b_ready = !w_b_full;
  assign bus.regWr   = r_regWr;
  assign bus.rw      = r_rw;
  assign bus.busW    = r_busW;
  assign bus.pending = w_pend;
  assign bus.a_count = w_a_cnt;
  assign bus.b_count = w_b_cnt;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: vector table plus
// hand-written backpressure and discard sequences.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.DEPTH(2)) bus ();
  regfile_wr_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic        r;
    logic        av;
    logic [3:0]  aa;
    logic [15:0] ad;
    logic        bv;
    logic [3:0]  ba;
    logic [15:0] bd;
    logic        ewr;
    logic [3:0]  erw;
    logic [15:0] ebus;
    logic [15:0] epend;
    int          eac;
    int          ebc;
    logic        ear;
    logic        ebr;
  } vec_t;

  vec_t         tbl[$];
  logic [19:0]  clog[$];
  int           checks = 0;
  int           failures = 0;

  always @(negedge clk)
    if (bus.regWr === 1'b1) clog.push_back({bus.rw, bus.busW});

  function automatic vec_t v(
    logic r, logic av, logic [3:0] aa, logic [15:0] ad,
    logic bv, logic [3:0] ba, logic [15:0] bd,
    logic ewr, logic [3:0] erw, logic [15:0] ebus,
    logic [15:0] epend, int eac, int ebc,
    logic ear, logic ebr
  );
    vec_t t;
    t.r = r; t.av = av; t.aa = aa; t.ad = ad;
    t.bv = bv; t.ba = ba; t.bd = bd;
    t.ewr = ewr; t.erw = erw; t.ebus = ebus;
    t.epend = epend; t.eac = eac; t.ebc = ebc;
    t.ear = ear; t.ebr = ebr;
    return t;
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s [%0d]: got %0h want %0h",
               nm, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    rst = t.r;
    bus.a_valid = t.av; bus.a_addr = t.aa; bus.a_data = t.ad;
    bus.b_valid = t.bv; bus.b_addr = t.ba; bus.b_data = t.bd;
    @(posedge clk);
    #1;
    chk("regWr",   idx, 32'(bus.regWr),   32'(t.ewr));
    chk("rw",      idx, 32'(bus.rw),      32'(t.erw));
    chk("busW",    idx, 32'(bus.busW),    32'(t.ebus));
    chk("pending", idx, 32'(bus.pending), 32'(t.epend));
    chk("a_count", idx, 32'(bus.a_count), t.eac);
    chk("b_count", idx, 32'(bus.b_count), t.ebc);
    chk("a_ready", idx, 32'(bus.a_ready), 32'(t.ear));
    chk("b_ready", idx, 32'(bus.b_ready), 32'(t.ebr));
  endtask

  initial begin
    int ai, bi, cyc, nbad, na, nb;
    logic acc_a, acc_b, saw_full;
    rst = 1'b1;
    bus.a_valid = 0; bus.a_addr = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;

    // reset
    tbl.push_back(v(1, 0,0,0, 0,0,0, 0,0,0,16'h0000, 0,0,1,1));
    // tie, both streaming (held valid while not ready)
    tbl.push_back(v(0, 1,1,16'hA001, 1,9,16'hB009,
                    0,0,16'h0000,16'h0202, 1,1,1,1));
    tbl.push_back(v(0, 1,2,16'hA002, 1,10,16'hB00A,
                    1,1,16'hA001,16'h0606, 1,2,1,0));
    tbl.push_back(v(0, 1,3,16'hA003, 1,11,16'hB00B,
                    1,9,16'hB009,16'h060C, 2,1,0,1));
    // full A popped while a_valid=1: no push, 2->1
    tbl.push_back(v(0, 1,4,16'hA004, 1,11,16'hB00B,
                    1,2,16'hA002,16'h0C0C, 1,2,1,0));
    tbl.push_back(v(0, 1,4,16'hA004, 1,12,16'hB00C,
                    1,10,16'hB00A,16'h0C18, 2,1,0,1));
    tbl.push_back(v(0, 0,0,0, 1,12,16'hB00C,
                    1,3,16'hA003,16'h1818, 1,2,1,0));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,11,16'hB00B,16'h1810, 1,1,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,4,16'hA004,16'h1010, 0,1,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,12,16'hB00C,16'h1000, 0,0,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    0,12,16'hB00C,16'h0000, 0,0,1,1));
    // single write
    tbl.push_back(v(0, 1,3,16'h1234, 0,0,0,
                    0,12,16'hB00C,16'h0008, 1,0,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,3,16'h1234,16'h0008, 0,0,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    0,3,16'h1234,16'h0000, 0,0,1,1));
    // reset mid-operation at peak occupancy
    tbl.push_back(v(0, 1,5,16'hD005, 1,6,16'hD006,
                    0,3,16'h1234,16'h0060, 1,1,1,1));
    tbl.push_back(v(0, 1,7,16'hD007, 1,8,16'hD008,
                    1,6,16'hD006,16'h01E0, 2,1,0,1));
    tbl.push_back(v(1, 1,9,16'hD009, 1,10,16'hD00A,
                    0,0,16'h0000,16'h0000, 0,0,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    0,0,16'h0000,16'h0000, 0,0,1,1));
    // next tie after reset goes to A
    tbl.push_back(v(0, 1,1,16'hE001, 1,2,16'hE002,
                    0,0,16'h0000,16'h0006, 1,1,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,1,16'hE001,16'h0006, 0,1,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    1,2,16'hE002,16'h0004, 0,0,1,1));
    tbl.push_back(v(0, 0,0,0, 0,0,0,
                    0,2,16'hE002,16'h0000, 0,0,1,1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    nbad = 0;
    foreach (clog[k])
      if (clog[k][15:0] inside {16'hD005, 16'hD007,
                                16'hD008, 16'hD009, 16'hD00A})
        nbad++;
    chk("discarded_committed", 0, nbad, 0);

    // backpressure: B streams 10 writes, A pushes 3
    clog.delete();
    ai = 0; bi = 0; cyc = 0; saw_full = 0;
    while (cyc < 60 && !(ai == 3 && bi == 10 &&
           bus.a_count == 0 && bus.b_count == 0 &&
           bus.regWr == 1'b0)) begin
      bus.a_valid = (ai < 3);
      bus.a_addr  = 4'(1 + ai);
      bus.a_data  = 16'hC000 + 16'(ai);
      bus.b_valid = (bi < 10);
      bus.b_addr  = 4'(8 + (bi % 8));
      bus.b_data  = 16'hBB00 + 16'(bi);
      if (bus.a_count == 2) begin
        saw_full = 1;
        chk("a_ready_full", cyc, 32'(bus.a_ready), 0);
      end
      acc_a = bus.a_valid && bus.a_ready;
      acc_b = bus.b_valid && bus.b_ready;
      @(posedge clk);
      #1;
      if (acc_a) ai++;
      if (acc_b) bi++;
      cyc++;
    end
    bus.a_valid = 0; bus.b_valid = 0;
    chk("bp_timeout", 0, 32'(cyc < 60), 1);
    chk("bp_a_full_seen", 0, 32'(saw_full), 1);
    @(negedge clk);
    na = 0; nb = 0;
    foreach (clog[k]) begin
      if (clog[k][15:8] == 8'hC0) begin
        chk("bp_a_order", na, 32'(clog[k][15:0]),
            32'(16'hC000 + 16'(na)));
        chk("bp_a_addr", na, 32'(clog[k][19:16]), 1 + na);
        na++;
      end else begin
        chk("bp_b_order", nb, 32'(clog[k][15:0]),
            32'(16'hBB00 + 16'(nb)));
        nb++;
      end
    end
    chk("bp_a_commits", 0, na, 3);
    chk("bp_b_commits", 0, nb, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
